// File: rtl/rv32_instructions_pkg.sv
// Shared RV32 execution-cluster types: multiply opcode encoding and latency helper.
package rv32_instructions_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_operation_t;

    // Input register plus final fix-up register surround the core.
    localparam int unsigned MUL_FIXED_STAGES = 2;

    function automatic int unsigned mul_latency(input int unsigned core_stages);
        return core_stages + MUL_FIXED_STAGES;
    endfunction

endpackage

// File: rtl/stallable_array_multiplier.sv
// Unsigned array multiplier; partial-product rows are spread over CORE_STAGES
// enable-gated register stages (purely combinational when CORE_STAGES is 0).
module stallable_array_multiplier #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CORE_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic [2*DATA_WIDTH-1:0]   product_o
);

    localparam int unsigned PW   = 2 * DATA_WIDTH;
    localparam int unsigned ROWS = (CORE_STAGES == 0) ? DATA_WIDTH
                                 : (DATA_WIDTH + CORE_STAGES - 1) / CORE_STAGES;

    // Sum of the shifted partial-product rows with index in [lo, hi).
    function automatic logic [PW-1:0] row_sum(input logic [DATA_WIDTH-1:0] a,
                                              input logic [DATA_WIDTH-1:0] b,
                                              input int unsigned lo,
                                              input int unsigned hi);
        logic [PW-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (b[i] && (i >= lo) && (i < hi)) begin
                s = s + (PW'(a) << i);
            end
        end
        return s;
    endfunction

    if (CORE_STAGES == 0) begin : g_comb
        assign product_o = row_sum(a_i, b_i, 0, ROWS);
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] a_q   [CORE_STAGES];
        logic [DATA_WIDTH-1:0] b_q   [CORE_STAGES];
        logic [PW-1:0]         acc_q [CORE_STAGES];

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                for (int unsigned s = 0; s < CORE_STAGES; s++) begin
                    a_q[s]   <= '0;
                    b_q[s]   <= '0;
                    acc_q[s] <= '0;
                end
            end else if (en_i) begin
                a_q[0]   <= a_i;
                b_q[0]   <= b_i;
                acc_q[0] <= row_sum(a_i, b_i, 0, ROWS);
                for (int unsigned s = 1; s < CORE_STAGES; s++) begin
                    a_q[s]   <= a_q[s-1];
                    b_q[s]   <= b_q[s-1];
                    acc_q[s] <= acc_q[s-1]
                              + row_sum(a_q[s-1], b_q[s-1], s * ROWS, (s + 1) * ROWS);
                end
            end
        end

        assign product_o = acc_q[CORE_STAGES-1];
    end

endmodule

// File: rtl/pipelined_multiplication_unit.sv
// RV32M multiply unit: sign/magnitude input stage, stallable unsigned core,
// sign fix-up and half select on the way out, with tag passthrough and flush.
module pipelined_multiplication_unit
    import rv32_instructions_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CORE_STAGES = 2,
    parameter int unsigned TAG_WIDTH   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] multiplicand_i,
    input  logic [DATA_WIDTH-1:0] multiplier_i,
    input  mul_operation_t        operation_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic [DATA_WIDTH-1:0] product_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic                  stall_c;
    logic                  accept_c;
    logic                  advance_c;
    logic                  rs1_neg_c;
    logic                  rs2_neg_c;
    logic [DATA_WIDTH-1:0] rs1_mag_c;
    logic [DATA_WIDTH-1:0] rs2_mag_c;
    logic [DATA_WIDTH-1:0] rs1_mag_q;
    logic [DATA_WIDTH-1:0] rs2_mag_q;
    logic [PW-1:0]         core_product_c;
    logic [PW-1:0]         fixed_c;

    // Index 0 is S0; index k is core stage Sk, in lock-step with the core.
    logic                  valid_q [CORE_STAGES+1];
    mul_operation_t        op_q    [CORE_STAGES+1];
    logic                  neg_q   [CORE_STAGES+1];
    logic [TAG_WIDTH-1:0]  tag_q   [CORE_STAGES+1];

    assign stall_c   = valid_o & ~ready_i;
    assign ready_o   = ~stall_c;
    assign accept_c  = valid_i & ready_o & ~flush_i;
    assign advance_c = ~stall_c & ~flush_i;

    // Per-operand signedness: rs2 is unsigned for MULHSU, so its MSB is ignored.
    always_comb begin
        rs1_neg_c = 1'b0;
        rs2_neg_c = 1'b0;
        rs1_mag_c = multiplicand_i;
        rs2_mag_c = multiplier_i;
        if (operation_i != MULHU) begin
            rs1_neg_c = multiplicand_i[DATA_WIDTH-1];
        end
        if ((operation_i == MUL) || (operation_i == MULH)) begin
            rs2_neg_c = multiplier_i[DATA_WIDTH-1];
        end
        if (rs1_neg_c) begin
            rs1_mag_c = -multiplicand_i;
        end
        if (rs2_neg_c) begin
            rs2_mag_c = -multiplier_i;
        end
    end

    stallable_array_multiplier #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CORE_STAGES (CORE_STAGES)
    ) u_core (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (~stall_c),
        .a_i       (rs1_mag_q),
        .b_i       (rs2_mag_q),
        .product_o (core_product_c)
    );

    assign fixed_c = neg_q[CORE_STAGES] ? -core_product_c : core_product_c;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned s = 0; s <= CORE_STAGES; s++) begin
                valid_q[s] <= 1'b0;
                op_q[s]    <= MUL;
                neg_q[s]   <= 1'b0;
                tag_q[s]   <= '0;
            end
            rs1_mag_q <= '0;
            rs2_mag_q <= '0;
            valid_o   <= 1'b0;
            product_o <= '0;
            tag_o     <= '0;
        end else begin
            // Flush wins over stall; only the valid bits need clearing.
            if (flush_i) begin
                for (int unsigned s = 0; s <= CORE_STAGES; s++) begin
                    valid_q[s] <= 1'b0;
                end
                valid_o <= 1'b0;
            end else if (!stall_c) begin
                valid_q[0] <= accept_c;
                for (int unsigned s = 1; s <= CORE_STAGES; s++) begin
                    valid_q[s] <= valid_q[s-1];
                end
                valid_o <= valid_q[CORE_STAGES];
            end

            if (advance_c) begin
                rs1_mag_q <= rs1_mag_c;
                rs2_mag_q <= rs2_mag_c;
                op_q[0]   <= operation_i;
                neg_q[0]  <= rs1_neg_c ^ rs2_neg_c;
                tag_q[0]  <= tag_i;
                for (int unsigned s = 1; s <= CORE_STAGES; s++) begin
                    op_q[s]  <= op_q[s-1];
                    neg_q[s] <= neg_q[s-1];
                    tag_q[s] <= tag_q[s-1];
                end
                product_o <= (op_q[CORE_STAGES] == MUL) ? fixed_c[DATA_WIDTH-1:0]
                                                        : fixed_c[PW-1:DATA_WIDTH];
                tag_o     <= tag_q[CORE_STAGES];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_multiplication_unit.sv
// Self-checking bench for pipelined_multiplication_unit: directed table,
// random streaming against a signed-arithmetic model, stall, flush and reset.
module tb_pipelined_multiplication_unit;
    import rv32_instructions_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned CS  = 2;
    localparam int unsigned TW  = 6;
    localparam int unsigned LAT = mul_latency(CS);

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic           flush_i;
    logic           valid_i;
    logic           ready_o;
    logic [W-1:0]   multiplicand_i;
    logic [W-1:0]   multiplier_i;
    mul_operation_t operation_i;
    logic [TW-1:0]  tag_i;
    logic [W-1:0]   product_o;
    logic [TW-1:0]  tag_o;
    logic           valid_o;
    logic           ready_i;

    pipelined_multiplication_unit #(
        .DATA_WIDTH  (W),
        .CORE_STAGES (CS),
        .TAG_WIDTH   (TW)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .operation_i    (operation_i),
        .tag_i          (tag_i),
        .product_o      (product_o),
        .tag_o          (tag_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0]  prod;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        mul_operation_t op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [TW-1:0]  tag;
        logic [W-1:0]   exp;
    } vec_t;

    exp_t sb_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   vo_cnt   = 0;
    int   vo_first = -1;
    int   vo_last  = -1;

    // Reference: exact signed/unsigned product in wide arithmetic.
    function automatic logic [W-1:0] ref_mul(input mul_operation_t op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic                  s1;
        logic                  s2;
        logic signed [2*W+1:0] p;
        s1 = (op != MULHU);
        s2 = (op == MUL) || (op == MULH);
        p  = $signed({s1 & a[W-1], a}) * $signed({s2 & b[W-1], b});
        return (op == MUL) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return W'(32'h8000_0000);
            1:       return W'(32'hFFFF_FFFF);
            2:       return W'(0);
            3:       return W'(32'h7FFF_FFFF);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic new_bundle();
        operation_i    = mul_operation_t'($urandom_range(0, 3));
        multiplicand_i = pick();
        multiplier_i   = pick();
        tag_i          = TW'($urandom);
    endtask

    // Present the current bundle for one cycle; refresh it only once taken.
    task automatic step();
        logic acc;
        #1;
        acc = valid_i && ready_o && !flush_i;
        @(posedge clk_i); #1;
        if (acc) new_bundle();
    endtask

    task automatic run_single(input mul_operation_t op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [TW-1:0] tag,
                              input logic [W-1:0] exp, input string name);
        int n;
        operation_i    = op;
        multiplicand_i = a;
        multiplier_i   = b;
        tag_i          = tag;
        valid_i        = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(LAT));
        chk({name, "_product"}, 64'(product_o), 64'(exp));
        chk({name, "_tag"}, 64'(tag_o), 64'(tag));
        @(posedge clk_i); #1;
    endtask

    // Scoreboard: sampled mid-cycle, reflecting what the next edge will do.
    always @(negedge clk_i) begin
        exp_t e;
        cyc++;
        if (rst_n_i) begin
            if (valid_o && ready_i) begin
                checks++;
                vo_cnt++;
                if (vo_first < 0) vo_first = cyc;
                vo_last = cyc;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: valid_o with product %0h tag %0h, required no result",
                             product_o, tag_o);
                end else begin
                    e = sb_q.pop_front();
                    if (product_o !== e.prod || tag_o !== e.tag) begin
                        errors++;
                        $display("FAIL sb_result: product %0h tag %0h, required product %0h tag %0h",
                                 product_o, tag_o, e.prod, e.tag);
                    end
                end
            end
            if (flush_i) begin
                sb_q.delete();
            end else if (valid_i && ready_o) begin
                sb_q.push_back('{prod: ref_mul(operation_i, multiplicand_i, multiplier_i), tag: tag_i});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          vecs[10];
        logic [W-1:0]  snap_p;
        logic [TW-1:0] snap_t;
        int            n;

        vecs[0] = '{MULH,   32'h8000_0000, 32'h8000_0000, 6'h11, 32'h4000_0000};
        vecs[1] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h12, 32'hFFFF_FFFF};
        vecs[2] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h13, 32'hFFFF_FFFE};
        vecs[3] = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h14, 32'h0000_0001};
        vecs[4] = '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 6'h15, 32'hFFFF_FFEB};
        vecs[5] = '{MULH,   32'h0000_0007, 32'hFFFF_FFFD, 6'h16, 32'hFFFF_FFFF};
        vecs[6] = '{MULHSU, 32'h8000_0000, 32'h8000_0000, 6'h17, 32'hC000_0000};
        vecs[7] = '{MULHU,  32'h8000_0000, 32'h8000_0000, 6'h18, 32'h4000_0000};
        vecs[8] = '{MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'h19, 32'h3FFF_FFFF};
        vecs[9] = '{MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 6'h1A, 32'h0000_0001};

        rst_n_i        = 1'b0;
        flush_i        = 1'b0;
        valid_i        = 1'b0;
        ready_i        = 1'b1;
        operation_i    = MUL;
        multiplicand_i = '0;
        multiplier_i   = '0;
        tag_i          = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_valid_o", 64'(valid_o), 64'(0));
        chk("reset_product_o", 64'(product_o), 64'(0));
        chk("reset_tag_o", 64'(tag_o), 64'(0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("reset_ready_o", 64'(ready_o), 64'(1));

        for (int i = 0; i < 10; i++) begin
            run_single(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
                       $sformatf("vec%0d", i));
        end

        // Back-to-back random stream, no backpressure.
        vo_cnt = 0; vo_first = -1; vo_last = -1;
        for (int i = 0; i < 100; i++) begin
            new_bundle();
            valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        repeat (LAT + 2) begin @(posedge clk_i); #1; end
        chk("stream_count", 64'(vo_cnt), 64'(100));
        chk("stream_no_bubble", 64'(vo_last - vo_first), 64'(99));
        chk("stream_drained", 64'(sb_q.size()), 64'(0));

        // Backpressure: stall 5 cycles once results appear.
        new_bundle();
        valid_i = 1'b1;
        n = 0;
        while (!valid_o && n < 20) begin step(); n++; end
        chk("bp_valid_rise", 64'(valid_o), 64'(1));
        ready_i = 1'b0;
        snap_p  = product_o;
        snap_t  = tag_o;
        repeat (5) begin
            step();
            chk("bp_ready_o", 64'(ready_o), 64'(0));
            chk("bp_valid_hold", 64'(valid_o), 64'(1));
            chk("bp_product_hold", 64'(product_o), 64'(snap_p));
            chk("bp_tag_hold", 64'(tag_o), 64'(snap_t));
        end
        ready_i = 1'b1;
        repeat (6) step();
        valid_i = 1'b0;
        repeat (LAT + 2) begin @(posedge clk_i); #1; end
        chk("bp_drained", 64'(sb_q.size()), 64'(0));

        // Flush with three in flight plus a same-cycle bundle.
        for (int i = 0; i < 3; i++) begin
            new_bundle();
            valid_i = 1'b1;
            @(posedge clk_i); #1;
        end
        new_bundle();
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_ready_o", 64'(ready_o), 64'(1));
        repeat (LAT + 2) begin
            chk("flush_no_valid", 64'(valid_o), 64'(0));
            @(posedge clk_i); #1;
        end
        chk("flush_queue_empty", 64'(sb_q.size()), 64'(0));
        run_single(MULH, 32'h8000_0000, 32'h8000_0000, 6'h2A, 32'h4000_0000, "post_flush");

        // Asynchronous reset between edges while results are streaming.
        for (int i = 0; i < int'(LAT) + 3; i++) begin
            new_bundle();
            multiplicand_i = 32'hDEAD_BEEF;
            multiplier_i   = 32'h1234_5679;
            operation_i    = MULHU;
            tag_i          = 6'h3F;
            valid_i        = 1'b1;
            @(posedge clk_i); #1;
        end
        chk("pre_reset_valid_o", 64'(valid_o), 64'(1));
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_reset_valid_o", 64'(valid_o), 64'(0));
        chk("async_reset_product_o", 64'(product_o), 64'(0));
        chk("async_reset_tag_o", 64'(tag_o), 64'(0));
        sb_q.delete();
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        #1;
        chk("post_reset_ready_o", 64'(ready_o), 64'(1));
        chk("post_reset_valid_o", 64'(valid_o), 64'(0));
        @(posedge clk_i); #1;
        run_single(MUL, 32'h1234_5678, 32'h9ABC_DEF0, 6'h05,
                   ref_mul(MUL, 32'h1234_5678, 32'h9ABC_DEF0), "post_reset");
        repeat (3) begin @(posedge clk_i); #1; end
        chk("final_queue_empty", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
